ttt_auto_opponent: RTL and testbench

TTT_AUTO_OPPONENT -- requirements
Module: ttt_auto_opponent

---
 rtl/ttt_pkg.sv | 49 ++++
 rtl/ttt_line_eval.sv | 36 +++
 rtl/ttt_auto_opponent.sv | 183 ++++++++++++++++++
 tb/tb_ttt_auto_opponent.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe auto opponent: cell/result codes,
// FSM state constants, the winning-line table, preference order and ack timeout.
package ttt_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY   = 2'b00,
    CELL_PLAYER  = 2'b01,
    CELL_COMP    = 2'b10,
    CELL_BLOCKED = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    WHO_IN_PROGRESS = 2'b00,
    WHO_PLAYER_WON  = 2'b01,
    WHO_COMP_WON    = 2'b10,
    WHO_DRAW        = 2'b11
  } who_t;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SCAN_WIN = 3'd1;
  localparam state_t ST_SCAN_BLK = 3'd2;
  localparam state_t ST_PREF     = 3'd3;
  localparam state_t ST_ISSUE    = 3'd4;
  localparam state_t ST_WAIT_ACK = 3'd5;

  localparam int NUM_LINES   = 8;
  localparam int ACK_TIMEOUT = 16;

  // LINE_TABLE[k][j] is cell j of line k; entries are listed from line 7 down to line 0,
  // and within a line from cell 2 down to cell 0.
  localparam logic [NUM_LINES-1:0][2:0][3:0] LINE_TABLE = {
    {4'd6, 4'd4, 4'd2},
    {4'd8, 4'd4, 4'd0},
    {4'd8, 4'd5, 4'd2},
    {4'd7, 4'd4, 4'd1},
    {4'd6, 4'd3, 4'd0},
    {4'd8, 4'd7, 4'd6},
    {4'd5, 4'd4, 4'd3},
    {4'd2, 4'd1, 4'd0}
  };

  // PREF_ORDER[0] is tried first: centre, corners, then edges.
  localparam logic [8:0][3:0] PREF_ORDER = {
    4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4
  };

endpackage

// File: rtl/ttt_line_eval.sv
// Combinational evaluation of one three-cell line: hit when exactly two cells
// belong to the owner and the third is empty; empty_pos locates that empty cell.
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] cell0,
  input  logic [1:0] cell1,
  input  logic [1:0] cell2,
  input  logic [1:0] owner,
  output logic       hit,
  output logic [1:0] empty_pos
);

  logic [2:0][1:0] cells;
  logic [2:0]      is_own;
  logic [2:0]      is_empty;

  assign cells = {cell2, cell1, cell0};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cell
    assign is_own[gi]   = (cells[gi] == owner);
    assign is_empty[gi] = (cells[gi] == CELL_EMPTY);
  end

  assign hit = ($countones(is_own) == 2) && ($countones(is_empty) == 1);

  always_comb begin
    empty_pos = 2'd0;
    if (is_empty[2]) begin
      empty_pos = 2'd2;
    end else if (is_empty[1]) begin
      empty_pos = 2'd1;
    end
  end

endmodule

// File: rtl/ttt_auto_opponent.sv
// Computer opponent: snapshots the board on trigger, scans for a win, then a block
// (only when TTT_OPP_BLOCK_EN is defined), then a preferred cell, and strobes pc.
module ttt_auto_opponent
  import ttt_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       auto_en,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] who,
  output logic       pc,
  output logic [3:0] computer_position,
  output logic       busy,
  output logic       err
);

  logic [8:0][1:0] board;
  logic [8:0]      is_player;
  logic [8:0]      is_comp;
  logic            trigger;
  logic            abort;
  logic            ack;

  state_t          state_reg, state_next;
  logic [8:0][1:0] snap_reg, snap_next;
  logic [2:0]      line_idx_reg, line_idx_next;
  logic [3:0]      tmo_cnt_reg, tmo_cnt_next;
  logic [3:0]      cpos_reg, cpos_next;
  logic            err_reg, err_next;

  logic [2:0][3:0] scan_cell_idx;
  logic [2:0][1:0] scan_cell;
  logic [1:0]      scan_owner;
  logic            scan_hit;
  logic [1:0]      scan_empty_pos;
  logic [3:0]      scan_sel;

  logic            pref_found;
  logic [3:0]      pref_cell;

  assign board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  for (genvar gi = 0; gi < 9; gi++) begin : g_count
    assign is_player[gi] = (board[gi] == CELL_PLAYER);
    assign is_comp[gi]   = (board[gi] == CELL_COMP);
  end

  // A move is owed only when the player has just moved (one piece ahead).
  assign trigger = auto_en && (who == WHO_IN_PROGRESS) && !err_reg &&
                   ($countones(is_player) == $countones(is_comp) + 1);
  assign abort   = (who != WHO_IN_PROGRESS);
  assign ack     = (board[cpos_reg] == CELL_COMP);

  for (genvar gi = 0; gi < 3; gi++) begin : g_scan
    assign scan_cell_idx[gi] = LINE_TABLE[line_idx_reg][gi];
    assign scan_cell[gi]     = snap_reg[scan_cell_idx[gi]];
  end

  assign scan_owner = (state_reg == ST_SCAN_BLK) ? CELL_PLAYER : CELL_COMP;

  ttt_line_eval u_line_eval (
    .cell0     (scan_cell[0]),
    .cell1     (scan_cell[1]),
    .cell2     (scan_cell[2]),
    .owner     (scan_owner),
    .hit       (scan_hit),
    .empty_pos (scan_empty_pos)
  );

  assign scan_sel = scan_cell_idx[scan_empty_pos];

  // Walk the order backwards so the earliest empty entry is the last one written.
  always_comb begin
    pref_found = 1'b0;
    pref_cell  = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (snap_reg[PREF_ORDER[i]] == CELL_EMPTY) begin
        pref_found = 1'b1;
        pref_cell  = PREF_ORDER[i];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    snap_next     = snap_reg;
    line_idx_next = line_idx_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    cpos_next     = cpos_reg;
    err_next      = err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (trigger) begin
          snap_next     = board;
          line_idx_next = 3'd0;
          state_next    = ST_SCAN_WIN;
        end
      end

      ST_SCAN_WIN, ST_SCAN_BLK: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (scan_hit) begin
          cpos_next  = scan_sel;
          state_next = ST_ISSUE;
        end else if (line_idx_reg == 3'(NUM_LINES - 1)) begin
          line_idx_next = 3'd0;
`ifdef TTT_OPP_BLOCK_EN
          state_next = (state_reg == ST_SCAN_WIN) ? ST_SCAN_BLK : ST_PREF;
`else
          state_next = ST_PREF;
`endif
        end else begin
          line_idx_next = line_idx_reg + 3'd1;
        end
      end

      ST_PREF: begin
        if (abort || !pref_found) begin
          state_next = ST_IDLE;
        end else begin
          cpos_next  = pref_cell;
          state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          tmo_cnt_next = 4'd0;
          state_next   = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        if (abort || ack) begin
          state_next = ST_IDLE;
        end else if (tmo_cnt_reg == 4'(ACK_TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 4'd1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      snap_reg     <= '0;
      line_idx_reg <= 3'd0;
      tmo_cnt_reg  <= 4'd0;
      cpos_reg     <= 4'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      snap_reg     <= snap_next;
      line_idx_reg <= line_idx_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      cpos_reg     <= cpos_next;
      err_reg      <= err_next;
    end
  end

  assign pc                = (state_reg == ST_ISSUE);
  assign busy              = (state_reg != ST_IDLE);
  assign err               = err_reg;
  assign computer_position = cpos_reg;

endmodule

// File: tb/tb_ttt_auto_opponent.sv
// Scoreboard bench for ttt_auto_opponent: directed scenarios plus random boards,
// expected moves and pc timing come from a rule-level model of the opponent.
module tb_ttt_auto_opponent;

  logic       clock = 1'b0;
  logic       reset;
  logic       auto_en;
  logic [1:0] who;
  logic [1:0] bd [9];
  logic       pc;
  logic [3:0] computer_position;
  logic       busy;
  logic       err;

  ttt_auto_opponent dut (
    .clock             (clock),
    .reset             (reset),
    .auto_en           (auto_en),
    .pos1              (bd[0]),
    .pos2              (bd[1]),
    .pos3              (bd[2]),
    .pos4              (bd[3]),
    .pos5              (bd[4]),
    .pos6              (bd[5]),
    .pos7              (bd[6]),
    .pos8              (bd[7]),
    .pos9              (bd[8]),
    .who               (who),
    .pc                (pc),
    .computer_position (computer_position),
    .busy              (busy),
    .err               (err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cycle;
    int pos;
  } exp_t;
  exp_t sb [$];

  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int pref [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

`ifdef TTT_OPP_BLOCK_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: first line (in table order) completing for the computer, then blocking
  // the player, else first empty cell in preference order. Each line costs a cycle.
  function automatic void model(input logic [1:0] b [9], output int mv, output int lat);
    mv  = -1;
    lat = 0;
    for (int p = 0; p < PASSES; p++) begin
      logic [1:0] own;
      own = (p == 0) ? 2'b10 : 2'b01;
      for (int k = 0; k < 8; k++) begin
        int n_own, n_emp, emp;
        n_own = 0; n_emp = 0; emp = -1;
        for (int j = 0; j < 3; j++) begin
          if (b[lines[k][j]] == own) n_own++;
          if (b[lines[k][j]] == 2'b00) begin n_emp++; emp = lines[k][j]; end
        end
        if (mv < 0 && n_own == 2 && n_emp == 1) begin
          mv  = emp;
          lat = 2 + 8 * p + k;
        end
      end
    end
    if (mv < 0) begin
      lat = 2 + 8 * PASSES;
      for (int i = 8; i >= 0; i--)
        if (b[pref[i]] == 2'b00) mv = pref[i];
    end
  endfunction

  // Monitor: every pc pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (pc === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pc", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pc_cycle", cyc, e.cycle);
          chk("pc_position", int'(computer_position), e.pos);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_position", int'(computer_position), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic watch_idle(input string name, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clock);
      if (busy) seen = 1;
    end
    chk(name, seen, 0);
  endtask

  task automatic run_game(input logic [1:0] b [9], input int d, input string tag);
    int mv, lat, t, p;
    bit got;
    model(b, mv, lat);
    @(posedge clock); #1;
    bd = b;
    who = 2'b00;
    auto_en = 1'b1;
    t = cyc;
    if (mv >= 0) begin
      exp_t e;
      e.cycle = t + lat;
      e.pos   = mv;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    auto_en = 1'b0;
    if (mv < 0) begin
      repeat (lat - 1) @(negedge clock);
      chk("nomove_busy", int'(busy), 1);
      @(negedge clock);
      chk("nomove_idle", int'(busy), 0);
      $display("%s: no move, idle at T+%0d", tag, lat);
      return;
    end
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (pc) begin got = 1; break; end
    end
    chk("pc_seen", int'(got), 1);
    if (!got) begin
      sb.delete();
      return;
    end
    p = cyc;
    if (d <= 16) begin
      repeat (d) @(posedge clock);
      #1;
      bd[mv] = 2'b10;
      @(negedge clock);
      chk("wait_ack_busy", int'(busy), 1);
      @(negedge clock);
      chk("ack_idle", int'(busy), 0);
      chk("ack_err", int'(err), 0);
      chk("position_hold", int'(computer_position), mv);
    end else begin
      repeat (16) @(negedge clock);
      chk("pre_timeout_busy", int'(busy), 1);
      chk("pre_timeout_err", int'(err), 0);
      @(negedge clock);
      chk("timeout_idle", int'(busy), 0);
      chk("timeout_err", int'(err), 1);
      @(posedge clock); #1;
      auto_en = 1'b1;
      watch_idle("err_blocks_trigger", 20);
      chk("err_sticky", int'(err), 1);
      auto_en = 1'b0;
      do_reset();
    end
    $display("%s: move %0d at T+%0d (pc cycle %0d), ack delay %0d", tag, mv, lat, p - t, d);
  endtask

  function automatic void rand_board(output logic [1:0] b [9]);
    int np, idx;
    for (int i = 0; i < 9; i++) b[i] = 2'b00;
    np = $urandom_range(1, 5);
    for (int n = 0; n < 2 * np; n++) begin
      logic [1:0] code;
      if (n == 2 * np - 1) break;
      code = (n < np) ? 2'b01 : 2'b10;
      do idx = $urandom_range(0, 8); while (b[idx] != 2'b00);
      b[idx] = code;
    end
    if (2 * np - 1 < 9 && $urandom_range(0, 3) == 0) begin
      do idx = $urandom_range(0, 8); while (b[idx] != 2'b00);
      b[idx] = 2'b11;
    end
  endfunction

  initial begin
    logic [1:0] b [9];
    int t, rcyc;

    reset = 1'b1;
    auto_en = 1'b0;
    who = 2'b00;
    for (int i = 0; i < 9; i++) bd[i] = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    chk("init_pc", int'(pc), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_err", int'(err), 0);
    chk("init_position", int'(computer_position), 0);
    reset = 1'b0;

    // Player at cell 0 only: preference picks the centre.
    for (int i = 0; i < 9; i++) b[i] = 2'b00;
    b[0] = 2'b01;
    run_game(b, 1, "pref_centre");

    // Player 0,1,8; computer 2,4: win on the anti-diagonal at cell 6.
    for (int i = 0; i < 9; i++) b[i] = 2'b00;
    b[0] = 2'b01; b[1] = 2'b01; b[8] = 2'b01; b[2] = 2'b10; b[4] = 2'b10;
    run_game(b, 5, "win_line7");

    // Player 0,1; computer 4: block (or preference) at cell 2.
    for (int i = 0; i < 9; i++) b[i] = 2'b00;
    b[0] = 2'b01; b[1] = 2'b01; b[4] = 2'b10;
    run_game(b, 16, "block_line0");

    // Abort from SCAN_WIN when the game ends.
    for (int i = 0; i < 9; i++) b[i] = 2'b00;
    b[0] = 2'b01;
    @(posedge clock); #1;
    bd = b; auto_en = 1'b1; t = cyc;
    @(posedge clock); #1;
    auto_en = 1'b0;
    @(posedge clock); #1;
    who = 2'b01;
    @(negedge clock);
    chk("abort_scan_busy", int'(busy), 1);
    @(negedge clock);
    chk("abort_idle", int'(busy), 0);
    @(posedge clock); #1;
    who = 2'b00;
    watch_idle("abort_no_restart", 25);
    chk("abort_position_kept", int'(computer_position), 2);
    $display("abort: who=01 at T+2, idle at T+3");

    // Asynchronous reset in the middle of a search.
`ifdef TTT_OPP_BLOCK_EN
    rcyc = 11;
`else
    rcyc = 5;
`endif
    @(posedge clock); #1;
    bd = b; auto_en = 1'b1; t = cyc;
    @(posedge clock); #1;
    auto_en = 1'b0;
    repeat (rcyc - 1) @(posedge clock);
    #1;
    chk("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("midscan_rst_pc", int'(pc), 0);
    chk("midscan_rst_busy", int'(busy), 0);
    chk("midscan_rst_err", int'(err), 0);
    chk("midscan_rst_position", int'(computer_position), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    watch_idle("post_reset_idle", 30);
    $display("reset: asserted at T+%0d mid-search", rcyc);

    // No acknowledge: timeout sets err, blocks triggers, reset clears it.
    run_game(b, 20, "ack_timeout");

    for (int g = 0; g < 30; g++) begin
      int d;
      rand_board(b);
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(17, 20) : $urandom_range(1, 16);
      run_game(b, d, $sformatf("random_%0d", g));
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
